// File: rtl/uart_rx_packer_if.sv
// Byte-stream, RX FIFO write and status signals of the UART RX packer.
// The master side is the packer; the slave side is the byte source / FIFO / host.
interface uart_rx_packer_if;
  logic        uart_re_i;
  logic        uart_rxvld_i;
  logic [7:0]  uart_rxdata_i;
  logic        uart_rxerr_i;
  logic        uart_rxfifo_full_i;
  logic        uart_rxfifo_wren_o;
  logic [31:0] uart_rxfifo_data_o;
  logic [2:0]  uart_rxfifo_bcnt_o;
  logic        ovf_flag_o;
  logic [7:0]  err_cnt_o;
  logic        stat_clr_i;

  modport master (
    input  uart_re_i, uart_rxvld_i, uart_rxdata_i, uart_rxerr_i,
           uart_rxfifo_full_i, stat_clr_i,
    output uart_rxfifo_wren_o, uart_rxfifo_data_o, uart_rxfifo_bcnt_o,
           ovf_flag_o, err_cnt_o
  );

  modport slave (
    output uart_re_i, uart_rxvld_i, uart_rxdata_i, uart_rxerr_i,
           uart_rxfifo_full_i, stat_clr_i,
    input  uart_rxfifo_wren_o, uart_rxfifo_data_o, uart_rxfifo_bcnt_o,
           ovf_flag_o, err_cnt_o
  );
endinterface

// File: rtl/uart_rx_packer.sv
// Packs received UART bytes little-endian into 32-bit RX FIFO words, with a
// one-word pending hold while the FIFO is full and an idle-timeout partial flush.
module uart_rx_packer #(
  parameter logic [31:0] TIMEOUT_CYC = 32'd43_400
) (
  input  logic            clk_i,
  input  logic            rst_i,
  uart_rx_packer_if.master bus
);

  logic [31:0] asm_data;
  logic [2:0]  asm_cnt;
  logic [31:0] idle_cnt;
  logic        pend_vld;
  logic [31:0] pend_data;
  logic [2:0]  pend_bcnt;
  logic        ovf_flag;
  logic [7:0]  err_cnt;

  logic        accept;
  logic        err_byte;
  logic        wren;
  logic        pend_free;
  logic        word_done;
  logic        flush;
  logic        ovf_set;
  logic [31:0] full_word;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign accept    = bus.uart_rxvld_i & bus.uart_re_i & ~bus.uart_rxerr_i;
  assign err_byte  = bus.uart_rxvld_i & bus.uart_re_i &  bus.uart_rxerr_i;
  assign wren      = pend_vld & ~bus.uart_rxfifo_full_i;
  // A pend slot being written this cycle may be reloaded on the same edge.
  assign pend_free = ~pend_vld | wren;
  assign word_done = accept & (asm_cnt == 3'd3);
  assign flush     = ~accept & (asm_cnt != 3'd0) & (idle_cnt == TIMEOUT_CYC) & pend_free;
  assign ovf_set   = word_done & ~pend_free;
  assign full_word = {bus.uart_rxdata_i, asm_data[23:0]};

  assign bus.uart_rxfifo_wren_o = wren;
  assign bus.uart_rxfifo_data_o = pend_data;
  assign bus.uart_rxfifo_bcnt_o = pend_bcnt;
  assign bus.ovf_flag_o         = ovf_flag;
  assign bus.err_cnt_o          = err_cnt;

  // Assembly of the partial word and its idle timer.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      asm_data <= 32'd0;
      asm_cnt  <= 3'd0;
      idle_cnt <= 32'd0;
    end else if (accept) begin
      idle_cnt <= 32'd0;
      if (word_done) begin
        asm_data <= 32'd0;
        asm_cnt  <= 3'd0;
      end else begin
        asm_data[{asm_cnt[1:0], 3'b000} +: 8] <= bus.uart_rxdata_i;
        asm_cnt <= asm_cnt + 3'd1;
      end
    end else if (flush) begin
      asm_data <= 32'd0;
      asm_cnt  <= 3'd0;
      idle_cnt <= 32'd0;
    end else if ((asm_cnt != 3'd0) && (idle_cnt != TIMEOUT_CYC)) begin
      idle_cnt <= idle_cnt + 32'd1;
    end
  end

  // Pending word register feeding the FIFO.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pend_vld  <= 1'b0;
      pend_data <= 32'd0;
      pend_bcnt <= 3'd0;
    end else if (word_done && pend_free) begin
      pend_vld  <= 1'b1;
      pend_data <= full_word;
      pend_bcnt <= 3'd4;
    end else if (flush) begin
      pend_vld  <= 1'b1;
      pend_data <= asm_data;
      pend_bcnt <= asm_cnt;
    end else if (wren) begin
      pend_vld  <= 1'b0;
    end
  end

  // Status: a set or increment in the same cycle takes priority over the clear.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ovf_flag <= 1'b0;
      err_cnt  <= 8'd0;
    end else begin
      if (ovf_set)             ovf_flag <= 1'b1;
      else if (bus.stat_clr_i) ovf_flag <= 1'b0;
      if (err_byte)            err_cnt  <= sat_inc8(err_cnt);
      else if (bus.stat_clr_i) err_cnt  <= 8'd0;
    end
  end

endmodule

// File: tb/tb_uart_rx_packer.sv
// Randomized and directed bench for uart_rx_packer against a queue-based reference model.
module tb_uart_rx_packer;
  localparam int T = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  uart_rx_packer_if bus();

  uart_rx_packer #(.TIMEOUT_CYC(32'd16)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // Reference model state
  logic [7:0]  m_q[$];
  int          m_idle;
  bit          m_pv;
  logic [31:0] m_pd;
  int          m_pb;
  bit          m_ovf;
  int          m_err;

  // Observed FIFO writes
  logic [31:0] wlog[$];
  int          wbcnt[$];
  int          wcyc[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] pack_q();
    logic [31:0] w = 32'd0;
    foreach (m_q[i]) w = w | (32'(m_q[i]) << (8 * i));
    return w;
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_idle = 0; m_pv = 0; m_pd = 0; m_pb = 0; m_ovf = 0; m_err = 0;
  endtask

  task automatic model_step();
    bit wr, fr, acc, eb, ovf_ev;
    logic [31:0] w;
    wr  = m_pv && !bus.uart_rxfifo_full_i;
    fr  = !m_pv || wr;
    acc = bus.uart_rxvld_i && bus.uart_re_i && !bus.uart_rxerr_i;
    eb  = bus.uart_rxvld_i && bus.uart_re_i && bus.uart_rxerr_i;
    ovf_ev = 0;
    if (wr) m_pv = 0;
    if (acc) begin
      m_q.push_back(bus.uart_rxdata_i);
      m_idle = 0;
      if (m_q.size() == 4) begin
        w = pack_q();
        m_q.delete();
        if (fr) begin m_pv = 1; m_pd = w; m_pb = 4; end
        else ovf_ev = 1;
      end
    end else if (m_q.size() > 0) begin
      if (m_idle == T && fr) begin
        m_pd = pack_q(); m_pb = m_q.size(); m_pv = 1;
        m_q.delete(); m_idle = 0;
      end else if (m_idle < T) begin
        m_idle++;
      end
    end
    if (ovf_ev) m_ovf = 1;
    else if (bus.stat_clr_i) m_ovf = 0;
    if (eb) m_err = (m_err == 255) ? 255 : m_err + 1;
    else if (bus.stat_clr_i) m_err = 0;
  endtask

  // One clock: compare at the falling edge, advance the model, return just after the rising edge.
  task automatic cycle();
    @(negedge clk);
    chk("wren", bus.uart_rxfifo_wren_o, (m_pv && !bus.uart_rxfifo_full_i && !rst) ? 1 : 0);
    chk("data", bus.uart_rxfifo_data_o, m_pd);
    chk("bcnt", bus.uart_rxfifo_bcnt_o, m_pb);
    chk("ovf",  bus.ovf_flag_o, m_ovf);
    chk("err",  bus.err_cnt_o, m_err);
    if (bus.uart_rxfifo_wren_o === 1'b1) begin
      wlog.push_back(bus.uart_rxfifo_data_o);
      wbcnt.push_back(int'(bus.uart_rxfifo_bcnt_o));
      wcyc.push_back(cyc);
    end
    if (rst) model_reset();
    else model_step();
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) cycle();
  endtask

  task automatic send(input logic [7:0] d, input bit e);
    bus.uart_rxvld_i  = 1'b1;
    bus.uart_rxdata_i = d;
    bus.uart_rxerr_i  = e;
    cycle();
    bus.uart_rxvld_i  = 1'b0;
    bus.uart_rxerr_i  = 1'b0;
    bus.uart_rxdata_i = 8'($urandom);
  endtask

  task automatic clr_log();
    wlog.delete(); wbcnt.delete(); wcyc.delete();
  endtask

  task automatic chk_write(input string tag, input logic [31:0] d, input int b);
    chk({tag, "_nwr"}, wlog.size(), 1);
    if (wlog.size() > 0) begin
      chk({tag, "_data"}, wlog[0], d);
      chk({tag, "_bcnt"}, wbcnt[0], b);
    end
  endtask

  initial begin
    int c_acc;
    logic [7:0] b0, b1, b2, b3;
    rst = 1'b1;
    bus.uart_re_i = 1'b1; bus.uart_rxvld_i = 1'b0; bus.uart_rxdata_i = 8'd0;
    bus.uart_rxerr_i = 1'b0; bus.uart_rxfifo_full_i = 1'b0; bus.stat_clr_i = 1'b0;
    model_reset();
    idle(2);
    chk("rst_wren", bus.uart_rxfifo_wren_o, 0);
    chk("rst_data", bus.uart_rxfifo_data_o, 0);
    chk("rst_bcnt", bus.uart_rxfifo_bcnt_o, 0);
    rst = 1'b0;
    idle(2);

    // Full word, one cycle latency
    clr_log();
    send(8'h11, 0); send(8'h22, 0); send(8'h33, 0);
    c_acc = cyc;
    send(8'h44, 0);
    idle(3);
    chk_write("word", 32'h44332211, 4);
    if (wcyc.size() > 0) chk("word_lat", wcyc[0] - c_acc, 1);

    // Partial word flushed by timeout
    clr_log();
    send(8'hAA, 0);
    c_acc = cyc;
    send(8'hBB, 0);
    idle(T + 8);
    chk_write("flush", 32'h0000BBAA, 2);
    if (wcyc.size() > 0) chk("flush_lat", wcyc[0] - c_acc, T + 2);

    // FIFO full: hold first word, drop second with overflow
    clr_log();
    bus.uart_rxfifo_full_i = 1'b1;
    for (int i = 1; i <= 8; i++) send(8'(i), 0);
    chk("hold_ovf", bus.ovf_flag_o, 1);
    chk("hold_nwr", wlog.size(), 0);
    chk("hold_data", bus.uart_rxfifo_data_o, 32'h04030201);
    bus.uart_rxfifo_full_i = 1'b0;
    idle(T + 6);
    chk_write("held", 32'h04030201, 4);
    bus.stat_clr_i = 1'b1; cycle(); bus.stat_clr_i = 1'b0;
    chk("ovf_clr", bus.ovf_flag_o, 0);

    // Error byte dropped from the middle of a word
    clr_log();
    b0 = 8'($urandom); b1 = 8'($urandom); b2 = 8'($urandom);
    send(b0, 0); send(b1, 0); send(b2, 0);
    send(8'($urandom), 1);
    send(8'h55, 0);
    chk("err_one", bus.err_cnt_o, 1);
    idle(2);
    chk_write("errword", {8'h55, b2, b1, b0}, 4);

    // Error counter saturation, receive disable
    for (int i = 0; i < 300; i++) send(8'($urandom), 1);
    chk("err_sat", bus.err_cnt_o, 255);
    bus.stat_clr_i = 1'b1; cycle(); bus.stat_clr_i = 1'b0;
    clr_log();
    bus.uart_re_i = 1'b0;
    send(8'h99, 1);
    for (int i = 0; i < 4; i++) send(8'($urandom), 0);
    idle(T + 8);
    chk("re0_err", bus.err_cnt_o, 0);
    chk("re0_nwr", wlog.size(), 0);
    bus.uart_re_i = 1'b1;
    b0 = 8'($urandom); b1 = 8'($urandom); b2 = 8'($urandom); b3 = 8'($urandom);
    send(b0, 0); send(b1, 0); send(b2, 0); send(b3, 0);
    idle(2);
    chk_write("re1", {b3, b2, b1, b0}, 4);

    // Reset mid-word
    clr_log();
    send(8'h12, 0); send(8'h34, 0);
    rst = 1'b1;
    model_reset();
    repeat (3) begin
      cycle();
      chk("inrst_wren", bus.uart_rxfifo_wren_o, 0);
      chk("inrst_data", bus.uart_rxfifo_data_o, 0);
      chk("inrst_bcnt", bus.uart_rxfifo_bcnt_o, 0);
    end
    rst = 1'b0;
    idle(2);
    send(8'hDE, 0); send(8'hAD, 0); send(8'hBE, 0); send(8'hEF, 0);
    idle(T + 8);
    chk_write("postrst", 32'hEFBEADDE, 4);

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 19) == 0) bus.uart_rxfifo_full_i = ~bus.uart_rxfifo_full_i;
      bus.uart_re_i    = ($urandom_range(0, 29) != 0);
      bus.stat_clr_i   = ($urandom_range(0, 99) == 0);
      bus.uart_rxvld_i = ($urandom_range(0, 2) == 0);
      bus.uart_rxerr_i = ($urandom_range(0, 9) == 0);
      bus.uart_rxdata_i = 8'($urandom);
      cycle();
      if ($urandom_range(0, 149) == 0) begin
        bus.uart_rxvld_i = 1'b0; bus.stat_clr_i = 1'b0;
        idle(T + $urandom_range(0, 8));
      end
    end
    bus.uart_rxvld_i = 1'b0; bus.uart_rxerr_i = 1'b0; bus.stat_clr_i = 1'b0;
    bus.uart_rxfifo_full_i = 1'b0; bus.uart_re_i = 1'b1;
    idle(2 * T + 8);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
